// File: rtl/field_scan_array.sv
// field_scan_array: word store that streams one bit-field per word, one per handshake
module field_scan_array #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 4,
  parameter int FIELD_LSB = 4,
  parameter int FIELD_W   = 2,
  parameter int AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               wr_drop,
  input  logic               start,
  input  logic               dir,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      out_idx,
  output logic [FIELD_W-1:0] out_field,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_idx, w_idx;
  logic             r_dir, w_dir, r_drop;
  logic             w_wr_ok, w_term;
  if (DEPTH < 2 || FIELD_LSB + FIELD_W > WIDTH) begin : g_bad_params
    $error("field_scan_array: need DEPTH >= 2 and FIELD_LSB+FIELD_W <= WIDTH");
  end
  assign w_wr_ok = wr_en && r_state == IDLE && {1'b0, wr_addr} < (AW+1)'(DEPTH);
  // terminal test comes before any step so idx never wraps
  assign w_term  = r_dir ? r_idx == '0 : r_idx == LAST;
  always_comb begin
    w_next = r_state;
    w_idx  = r_idx;
    w_dir  = r_dir;
    case (r_state)
      IDLE: if (start) begin
        w_next = SCAN;
        w_dir  = dir;
        w_idx  = dir ? LAST : '0;
      end
      SCAN: if (out_ready) begin
        w_next = w_term ? DONE : SCAN;
        w_idx  = w_term ? r_idx : (r_dir ? r_idx - ONE : r_idx + ONE);
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_dir   <= 1'b0;
      r_drop  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx;
      r_dir   <= w_dir;
      r_drop  <= wr_en && !w_wr_ok;
      if (w_wr_ok) r_mem[wr_addr] <= wr_data;
    end
  assign wr_drop   = r_drop;
  assign busy      = r_state != IDLE;
  assign out_valid = r_state == SCAN;
  assign done      = r_state == DONE;
  assign out_idx   = r_idx;
  assign out_field = r_mem[r_idx][FIELD_LSB +: FIELD_W];
endmodule

// File: tb/tb_field_scan_array.sv
// tb_field_scan_array: randomized check of field_scan_array against a word-array model
module tb_field_scan_array;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic        wr_en0 = 0, start0 = 0, dir0 = 0, ordy0 = 0;
  logic [1:0]  wr_addr0 = 0;
  logic [11:0] wr_data0 = 0;
  logic        wr_drop0, busy0, ov0, done0;
  logic [1:0]  oidx0, of0;
  logic        wr_en1 = 0, start1 = 0, dir1 = 0, ordy1 = 0;
  logic [2:0]  wr_addr1 = 0;
  logic [15:0] wr_data1 = 0;
  logic        wr_drop1, busy1, ov1, done1;
  logic [2:0]  oidx1;
  logic [3:0]  of1;
  logic [11:0] m0 [4];
  logic [15:0] m1 [5];
  int checks = 0, failures = 0;
  field_scan_array u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .wr_drop(wr_drop0), .start(start0), .dir(dir0), .busy(busy0), .out_valid(ov0),
    .out_ready(ordy0), .out_idx(oidx0), .out_field(of0), .done(done0)
  );
  field_scan_array #(.WIDTH(16), .DEPTH(5), .FIELD_LSB(12), .FIELD_W(4)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .wr_drop(wr_drop1), .start(start1), .dir(dir1), .busy(busy1), .out_valid(ov1),
    .out_ready(ordy1), .out_idx(oidx1), .out_field(of1), .done(done1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_models();
    for (int i = 0; i < 4; i++) m0[i] = '0;
    for (int i = 0; i < 5; i++) m1[i] = '0;
  endtask
  task automatic wr0(input logic [1:0] a, input logic [11:0] d);
    wr_en0 = 1; wr_addr0 = a; wr_data0 = d; m0[a] = d;
    @(negedge clk);
    wr_en0 = 0;
    check("w0_drop", wr_drop0, 0);
  endtask
  task automatic wr1(input logic [2:0] a, input logic [15:0] d);
    bit bad = a >= 5;
    wr_en1 = 1; wr_addr1 = a; wr_data1 = d;
    if (!bad) m1[a] = d;
    @(negedge clk);
    wr_en1 = 0;
    check("w1_drop", wr_drop1, bad);
  endtask
  // rmode: 0 ready always, 1 random ready, 2 fixed ready pattern 1,0,0,1,0,1,1
  task automatic scan0(input logic d, input int rmode, input bit drop, input bit ws,
                       input logic [1:0] wa, input logic [11:0] wd);
    int n = 0, cyc = 0, ei;
    logic [6:0] pat = 7'b1101001;
    check("s0_idle", busy0, 0);
    start0 = 1; dir0 = d;
    if (ws) begin wr_en0 = 1; wr_addr0 = wa; wr_data0 = wd; m0[wa] = wd; end
    @(negedge clk);
    start0 = 0; wr_en0 = 0;
    if (drop) begin wr_en0 = 1; wr_addr0 = 1; wr_data0 = 12'hFFF; end
    while (n < 4 && cyc < 64) begin
      ei = d ? 3 - n : n;
      check("s0_valid", ov0, 1);
      check("s0_busy", busy0, 1);
      check("s0_idx", oidx0, ei);
      check("s0_field", of0, (m0[ei] >> 4) & 3);
      if (cyc == 0) check("s0_drop0", wr_drop0, 0);
      if (cyc == 1) check("s0_drop1", wr_drop0, drop);
      ordy0 = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : pat[cyc % 7];
      @(negedge clk);
      wr_en0 = 0;
      if (ordy0) n++;
      cyc++;
    end
    check("s0_count", n, 4);
    if (rmode == 0) check("s0_latency", cyc, 4);
    check("s0_done", done0, 1);
    check("s0_dvalid", ov0, 0);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    check("s0_done_off", done0, 0);
    check("s0_end_busy", busy0, 0);
    check("s0_start_ign", ov0, 0);
  endtask
  task automatic scan1(input logic d, input bit rnd);
    int n = 0, cyc = 0, ei;
    start1 = 1; dir1 = d;
    @(negedge clk);
    start1 = 0;
    while (n < 5 && cyc < 80) begin
      ei = d ? 4 - n : n;
      check("s1_valid", ov1, 1);
      check("s1_idx", oidx1, ei);
      check("s1_field", of1, (m1[ei] >> 12) & 15);
      ordy1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (ordy1) n++;
      cyc++;
    end
    check("s1_count", n, 5);
    check("s1_done", done1, 1);
    @(negedge clk);
    check("s1_done_off", done1, 0);
    check("s1_end_busy", busy1, 0);
  endtask
  initial begin
    clear_models();
    #2;
    check("rst_busy", busy0, 0);
    check("rst_valid", ov0, 0);
    check("rst_done", done0, 0);
    check("rst_drop", wr_drop0, 0);
    check("rst_idx", oidx0, 0);
    check("rst_field", of0, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    wr0(0, 12'h012); wr0(1, 12'h345); wr0(2, 12'h678); wr0(3, 12'h9AB);
    scan0(0, 0, 0, 0, 0, 0);
    scan0(1, 0, 0, 0, 0, 0);
    scan0(0, 2, 0, 0, 0, 0);
    scan0(0, 0, 1, 0, 0, 0);
    scan0(0, 1, 0, 0, 0, 0);
    scan0(0, 0, 0, 1, 0, 12'h030);
    check("ws_first", (m0[0] >> 4) & 3, 3);
    for (int it = 0; it < 20; it++) begin
      for (int k = $urandom_range(0, 4); k > 0; k--) wr0(2'($urandom_range(0, 3)), 12'($urandom));
      scan0(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 12'($urandom));
    end
    start0 = 1; dir0 = 0; ordy0 = 1;
    @(negedge clk);
    start0 = 0;
    @(negedge clk); @(negedge clk);
    check("rst_pre_idx", oidx0, 2);
    #2 rst = 1;
    #1;
    check("arst_valid", ov0, 0);
    check("arst_busy", busy0, 0);
    check("arst_done", done0, 0);
    check("arst_idx", oidx0, 0);
    clear_models();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("arst_nodone", done0, 0);
    check("arst_idle", busy0, 0);
    scan0(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) wr1(3'(i), 16'((i + 1) << 12));
    scan1(0, 0);
    wr1(6, 16'hFFFF);
    scan1(0, 0);
    scan1(1, 1);
    for (int it = 0; it < 10; it++) begin
      for (int k = $urandom_range(0, 4); k > 0; k--) wr1(3'($urandom_range(0, 7)), 16'($urandom));
      scan1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
